fetch_stage: RTL and testbench

Front end of the five-stage pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register that feeds decode. Detects load-use hazards against the instruction in ID/EX, freezing PC and IF/ID and requesting a bubble into ID/EX. Accepts a branch/jump redirect resolved in ID, reloading PC and flushing IF/ID.

---
 rtl/fetch_stage_pkg.sv | 37 +++
 rtl/fetch_stage_if.sv | 34 +++
 rtl/fetch_stage_load_use_hazard.sv | 23 ++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants, instruction field helpers and fetch-stage types.
package fetch_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned CNT_W_DEF = 16;

    localparam logic [XLEN-1:0] NOP          = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC       = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    // Which update the PC and IF/ID registers take on the next edge.
    typedef enum logic [1:0] {
        ACT_IDLE     = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_ADVANCE  = 2'd3
    } fetch_act_e;

    // IF/ID pipeline register payload.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } ifid_t;

    function automatic logic [REG_AW-1:0] rs_of(input logic [XLEN-1:0] instr);
        return instr[RS_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] rt_of(input logic [XLEN-1:0] instr);
        return instr[RT_LSB +: REG_AW];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory, redirect, ID/EX hazard inputs and IF/ID outputs.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic              start_i;
    logic [XLEN-1:0]   pc_o;
    logic [XLEN-1:0]   instr_i;
    logic              redirect_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic              idex_memread_i;
    logic [REG_AW-1:0] idex_rt_i;
    logic [XLEN-1:0]   instr_o;
    logic [XLEN-1:0]   pc_plus4_o;
    logic              valid_o;
    logic              stall_o;
    logic              bubble_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    // Fetch stage side.
    modport master (
        input  start_i, instr_i, redirect_i, redirect_pc_i, idex_memread_i, idex_rt_i,
        output pc_o, instr_o, pc_plus4_o, valid_o, stall_o, bubble_o, stall_cnt_o
    );

    // Memory / rest-of-pipeline side.
    modport slave (
        output start_i, instr_i, redirect_i, redirect_pc_i, idex_memread_i, idex_rt_i,
        input  pc_o, instr_o, pc_plus4_o, valid_o, stall_o, bubble_o, stall_cnt_o
    );

endinterface

// File: rtl/fetch_stage_load_use_hazard.sv
// Load-use hazard compare between the IF/ID instruction and a load sitting in ID/EX.
module load_use_hazard
    import fetch_stage_pkg::*;
(
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic              i_idex_memread,
    input  logic [REG_AW-1:0] i_idex_rt,
    output logic              o_stall
);

    logic w_rt_nonzero;
    logic w_src_match;

    // Register zero never carries a dependency.
    always_comb begin
        w_rt_nonzero = (i_idex_rt != '0);
        w_src_match  = (i_idex_rt == i_rs) || (i_idex_rt == i_rt);
        o_stall      = i_valid & i_idex_memread & w_rt_nonzero & w_src_match;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, IF/ID register, load-use stall and branch redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     CNT_W    = CNT_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0]  r_pc;
    ifid_t            r_ifid;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  w_pc_plus4;
    ifid_t            w_ifid_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_stall;
    fetch_act_e       w_act;

    load_use_hazard u_hazard (
        .i_valid        (r_ifid.valid),
        .i_rs           (rs_of(r_ifid.instr)),
        .i_rt           (rt_of(r_ifid.instr)),
        .i_idex_memread (bus.idex_memread_i),
        .i_idex_rt      (bus.idex_rt_i),
        .o_stall        (w_stall)
    );

    // Edge priority: run enable, then load-use stall, then redirect, else advance.
    always_comb begin
        w_act = ACT_ADVANCE;
        if (!bus.start_i) begin
            w_act = ACT_IDLE;
        end else if (w_stall) begin
            w_act = ACT_STALL;
        end else if (bus.redirect_i) begin
            w_act = ACT_REDIRECT;
        end
    end

    // Next PC, IF/ID and stall counter for the selected action.
    always_comb begin
        w_pc_plus4  = r_pc + PC_INC;
        w_pc_next   = r_pc;
        w_ifid_next = r_ifid;
        w_cnt_next  = r_cnt;
        case (w_act)
            ACT_IDLE: begin
                w_ifid_next.instr = NOP;
                w_ifid_next.valid = 1'b0;
            end
            ACT_STALL: begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ACT_REDIRECT: begin
                // The word fetched this cycle is on the wrong path and is dropped.
                w_pc_next         = bus.redirect_pc_i;
                w_ifid_next.instr = NOP;
                w_ifid_next.valid = 1'b0;
            end
            ACT_ADVANCE: begin
                w_pc_next            = w_pc_plus4;
                w_ifid_next.instr    = bus.instr_i;
                w_ifid_next.pc_plus4 = w_pc_plus4;
                w_ifid_next.valid    = 1'b1;
            end
            default: begin
                w_pc_next = r_pc;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc   <= RESET_PC;
            r_ifid <= '{valid: 1'b0, pc_plus4: '0, instr: NOP};
            r_cnt  <= '0;
        end else begin
            r_pc   <= w_pc_next;
            r_ifid <= w_ifid_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign bus.pc_o        = r_pc;
    assign bus.instr_o     = r_ifid.instr;
    assign bus.pc_plus4_o  = r_ifid.pc_plus4;
    assign bus.valid_o     = r_ifid.valid;
    assign bus.stall_o     = w_stall;
    assign bus.bubble_o    = w_stall;
    assign bus.stall_cnt_o = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch, stalls, redirects, wrap, reset and counter saturation.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   tot = 0;
    int   bad = 0;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr    = 32'h0;

    fetch_stage_if #(.CNT_W(16)) bus ();
    fetch_stage_if #(.CNT_W(3))  bus2 ();

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    fetch_stage #(.RESET_PC(32'h0), .CNT_W(3))  dut2 (.clk_i(clk), .rst_i(rst2), .bus(bus2));

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] pc);
        return 32'hF000_0000 | {16'h0, pc[15:0]};
    endfunction

    assign bus.instr_i = ovr_en ? ovr : pat(bus.pc_o);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
        bus.idex_memread_i = 1'b0; bus.idex_rt_i = 5'd0;
        step(); step();
        tot++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=%h", bus.pc_o, 32'h0); end
        tot++; if (bus.instr_o !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=%h", bus.instr_o, 32'h0); end
        tot++; if (bus.pc_plus4_o !== 32'h0) begin bad++; $display("FAIL rst_pp4 got=%h want=%h", bus.pc_plus4_o, 32'h0); end
        tot++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.valid_o); end
        tot++; if (bus.stall_cnt_o !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h want=0", bus.stall_cnt_o); end
        tot++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", bus.stall_o); end
        rst = 1'b0;
        step();
        tot++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL idle_pc got=%h want=%h", bus.pc_o, 32'h0); end
    endtask

    task automatic test_fetch();
        bus.start_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            tot++; if (bus.pc_o !== 32'(4 * k)) begin bad++; $display("FAIL fetch_pc%0d got=%h want=%h", k, bus.pc_o, 32'(4 * k)); end
            tot++; if (bus.instr_o !== pat(32'(4 * (k - 1)))) begin bad++; $display("FAIL fetch_instr%0d got=%h want=%h", k, bus.instr_o, pat(32'(4 * (k - 1)))); end
            tot++; if (bus.pc_plus4_o !== 32'(4 * k)) begin bad++; $display("FAIL fetch_pp4_%0d got=%h want=%h", k, bus.pc_plus4_o, 32'(4 * k)); end
            tot++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL fetch_valid%0d got=%b want=1", k, bus.valid_o); end
        end
    endtask

    task automatic test_load_use();
        ovr = 32'h00A0_0000; ovr_en = 1'b1;
        step();
        ovr_en = 1'b0;
        bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd0; #1;
        tot++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL lu_rt0 got=%b want=0", bus.stall_o); end
        bus.idex_rt_i = 5'd5; #1;
        tot++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", bus.stall_o); end
        tot++; if (bus.bubble_o !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b want=1", bus.bubble_o); end
        step();
        tot++; if (bus.pc_o !== 32'h10) begin bad++; $display("FAIL lu_pc_hold got=%h want=%h", bus.pc_o, 32'h10); end
        tot++; if (bus.instr_o !== 32'h00A0_0000) begin bad++; $display("FAIL lu_instr_hold got=%h want=%h", bus.instr_o, 32'h00A0_0000); end
        tot++; if (bus.stall_cnt_o !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%h want=1", bus.stall_cnt_o); end
        bus.idex_memread_i = 1'b0; #1;
        tot++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL lu_clear got=%b want=0", bus.stall_o); end
        step();
        tot++; if (bus.pc_o !== 32'h14) begin bad++; $display("FAIL lu_resume_pc got=%h want=%h", bus.pc_o, 32'h14); end
        tot++; if (bus.instr_o !== pat(32'h10)) begin bad++; $display("FAIL lu_resume_instr got=%h want=%h", bus.instr_o, pat(32'h10)); end
        tot++; if (bus.stall_cnt_o !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold got=%h want=1", bus.stall_cnt_o); end
    endtask

    task automatic test_stall_vs_redirect();
        ovr = 32'h0003_0000; ovr_en = 1'b1;
        step();
        ovr_en = 1'b0;
        bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd3;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200; #1;
        tot++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL sr_stall_rt got=%b want=1", bus.stall_o); end
        step();
        tot++; if (bus.pc_o !== 32'h18) begin bad++; $display("FAIL sr_pc_hold got=%h want=%h", bus.pc_o, 32'h18); end
        tot++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL sr_valid_hold got=%b want=1", bus.valid_o); end
        tot++; if (bus.stall_cnt_o !== 16'd2) begin bad++; $display("FAIL sr_cnt got=%h want=2", bus.stall_cnt_o); end
        bus.idex_memread_i = 1'b0;
        step();
        tot++; if (bus.pc_o !== 32'h200) begin bad++; $display("FAIL sr_redir_pc got=%h want=%h", bus.pc_o, 32'h200); end
        tot++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL sr_redir_valid got=%b want=0", bus.valid_o); end
        tot++; if (bus.pc_plus4_o !== 32'h18) begin bad++; $display("FAIL sr_pp4_hold got=%h want=%h", bus.pc_plus4_o, 32'h18); end
        bus.redirect_i = 1'b0;
        step();
        tot++; if (bus.instr_o !== pat(32'h200)) begin bad++; $display("FAIL sr_target got=%h want=%h", bus.instr_o, pat(32'h200)); end
    endtask

    task automatic test_redirect();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
        step();
        tot++; if (bus.pc_o !== 32'h100) begin bad++; $display("FAIL rd_pc got=%h want=%h", bus.pc_o, 32'h100); end
        tot++; if (bus.instr_o !== 32'h0) begin bad++; $display("FAIL rd_flush got=%h want=0", bus.instr_o); end
        tot++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b want=0", bus.valid_o); end
        bus.redirect_i = 1'b0;
        step();
        tot++; if (bus.instr_o !== pat(32'h100)) begin bad++; $display("FAIL rd_target got=%h want=%h", bus.instr_o, pat(32'h100)); end
        tot++; if (bus.pc_plus4_o !== 32'h104) begin bad++; $display("FAIL rd_pp4 got=%h want=%h", bus.pc_plus4_o, 32'h104); end
    endtask

    task automatic test_wrap_and_start();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFC;
        step();
        bus.redirect_i = 1'b0;
        step();
        tot++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=0", bus.pc_o); end
        tot++; if (bus.pc_plus4_o !== 32'h0) begin bad++; $display("FAIL wrap_pp4 got=%h want=0", bus.pc_plus4_o); end
        tot++; if (bus.instr_o !== pat(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_instr got=%h want=%h", bus.instr_o, pat(32'hFFFF_FFFC)); end
        step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h123;
        step();
        tot++; if (bus.pc_o !== 32'h123) begin bad++; $display("FAIL rd_lowbits got=%h want=%h", bus.pc_o, 32'h123); end
        bus.redirect_i = 1'b0; bus.start_i = 1'b0;
        step();
        tot++; if (bus.pc_o !== 32'h123) begin bad++; $display("FAIL idle_pc_hold got=%h want=%h", bus.pc_o, 32'h123); end
        tot++; if (bus.pc_plus4_o !== 32'h4) begin bad++; $display("FAIL idle_pp4_hold got=%h want=%h", bus.pc_plus4_o, 32'h4); end
        tot++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus.valid_o); end
        bus.start_i = 1'b1;
        step();
        tot++; if (bus.instr_o !== pat(32'h123)) begin bad++; $display("FAIL start_instr got=%h want=%h", bus.instr_o, pat(32'h123)); end
        tot++; if (bus.pc_o !== 32'h127) begin bad++; $display("FAIL start_pc got=%h want=%h", bus.pc_o, 32'h127); end
    endtask

    task automatic test_reset_mid_stall();
        ovr = 32'h00A0_0000; ovr_en = 1'b1;
        step();
        ovr_en = 1'b0;
        bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd5;
        for (int k = 0; k < 5; k++) step();
        tot++; if (bus.stall_cnt_o !== 16'd7) begin bad++; $display("FAIL ms_cnt7 got=%h want=7", bus.stall_cnt_o); end
        tot++; if (bus.pc_o !== 32'h12B) begin bad++; $display("FAIL ms_pc_hold got=%h want=%h", bus.pc_o, 32'h12B); end
        rst = 1'b1;
        step();
        tot++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL ms_rst_pc got=%h want=0", bus.pc_o); end
        tot++; if (bus.stall_cnt_o !== 16'd0) begin bad++; $display("FAIL ms_rst_cnt got=%h want=0", bus.stall_cnt_o); end
        tot++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ms_rst_valid got=%b want=0", bus.valid_o); end
        tot++; if (bus.instr_o !== 32'h0) begin bad++; $display("FAIL ms_rst_instr got=%h want=0", bus.instr_o); end
        tot++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL ms_rst_stall got=%b want=0", bus.stall_o); end
        rst = 1'b0; bus.idex_memread_i = 1'b0;
        step();
        tot++; if (bus.pc_o !== 32'h4) begin bad++; $display("FAIL ms_post_pc got=%h want=4", bus.pc_o); end
        tot++; if (bus.instr_o !== pat(32'h0)) begin bad++; $display("FAIL ms_post_instr got=%h want=%h", bus.instr_o, pat(32'h0)); end
    endtask

    task automatic test_saturate();
        rst2 = 1'b1; bus2.start_i = 1'b1; bus2.instr_i = 32'h00A0_0000;
        bus2.redirect_i = 1'b0; bus2.redirect_pc_i = 32'h0;
        bus2.idex_memread_i = 1'b0; bus2.idex_rt_i = 5'd5;
        step();
        rst2 = 1'b0;
        step();
        bus2.idex_memread_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            tot++; if (bus2.stall_cnt_o !== 3'((k > 7) ? 7 : k)) begin bad++; $display("FAIL sat_cnt%0d got=%h want=%h", k, bus2.stall_cnt_o, 3'((k > 7) ? 7 : k)); end
        end
        tot++; if (bus2.pc_o !== 32'h4) begin bad++; $display("FAIL sat_pc_hold got=%h want=4", bus2.pc_o); end
    endtask

    initial begin
        bus2.start_i = 1'b0; bus2.instr_i = 32'h0; bus2.redirect_i = 1'b0;
        bus2.redirect_pc_i = 32'h0; bus2.idex_memread_i = 1'b0; bus2.idex_rt_i = 5'd0;
        test_reset();
        test_fetch();
        test_load_use();
        test_stall_vs_redirect();
        test_redirect();
        test_wrap_and_start();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
